riscv_writeback: RTL and testbench
==================================

RISCV_WRITEBACK -- requirements
Module: riscv_writeback

Interface
REQ-001 SHALL have parameter XLEN, default 32, data-path width.
REQ-002 SHALL have parameter RETIRE_W, default 32, retire-counter width.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk_i  in  1  rising-edge clock for all state.
REQ-005 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have port valid_i  in  1  upstream (memory stage) instruction valid.
REQ-007 SHALL have port stall_i  in  1  hold the stage register.
REQ-008 SHALL have port flush_i  in  1  kill the stage contents.
REQ-009 SHALL have port rd_i  in  5  destination register index.
REQ-010 SHALL have port reg_wen_i  in  1  instruction writes rd.
REQ-011 SHALL have port wb_sel_i  in  2  result source: 0 ALU, 1 MEM, 2 PC+4, 3 reserved.
REQ-012 SHALL have port funct3_i  in  3  load size/sign.
REQ-013 SHALL have port alu_result_i  in  XLEN  ALU result, also the load address.
REQ-014 SHALL have port pc_i  in  XLEN  instruction PC.
REQ-015 SHALL have port mem_rdata_i  in  XLEN  raw aligned word read from data memory.
REQ-016 SHALL have port DataD_o  out  XLEN  register-file write data.
REQ-017 SHALL have port AddrD_o  out  5  register-file write index.
REQ-018 SHALL have port RegWEn_o  out  1  register-file write enable.
REQ-019 SHALL have port wb_valid_o  out  1  an instruction retires this cycle.
REQ-020 SHALL have port misalign_o  out  1  one-cycle pulse on a misaligned load.
REQ-021 SHALL have port retired_o  out  RETIRE_W  count of retired instructions.

Function
REQ-022 SHALL capture all inputs into one stage register on a posedge where valid_i=1, stall_i=0 and flush_i=0; outputs are driven from that register (1-cycle latency).
REQ-023 SHALL hold the stage register and all outputs unchanged while stall_i=1 and flush_i=0.
REQ-024 SHALL give flush_i priority over stall_i and capture, clearing the stage valid bit on that edge; all other register contents are don't-care.
REQ-025 SHALL load a clear valid bit on an edge where valid_i=0, stall_i=0 and flush_i=0.
REQ-026 SHALL compute DataD_o from the registered source: ALU gives alu_result; MEM gives the aligned load value; PC+4 gives pc+4 modulo 2^XLEN; reserved gives 0.
REQ-027 SHALL align loads using byte offset alu_result[1:0] as follows:
- LB (000) and LBU (100): select the byte at that offset.
- LH (001) and LHU (101): select the halfword at offset[1].
- LW (010): return the whole word.
- LB/LH sign-extend; LBU/LHU zero-extend.
REQ-028 SHALL treat the following as misaligned: LH/LHU with offset[0]=1; LW with offset!=0; funct3 011, 110 or 111 with wb_sel=MEM.
REQ-029 SHALL assert RegWEn_o only when stage valid=1, reg_wen=1, rd!=0 and the instruction is not misaligned.
REQ-030 SHALL drive AddrD_o from the registered rd whenever stage valid=1, and drive 0 otherwise.
REQ-031 SHALL assert wb_valid_o for each cycle the stage holds a valid, non-misaligned instruction, counted once per instruction: deasserted during stall_i repeat cycles.
REQ-032 SHALL assert misalign_o for exactly one cycle per misaligned valid instruction, including when that instruction is held by a stall.
REQ-033 SHALL increment retired_o by 1 in each cycle wb_valid_o=1, wrapping from all-ones to 0.

Reset
REQ-034 SHALL, while rst_i=1 at a posedge, clear stage valid, DataD_o, AddrD_o, RegWEn_o, wb_valid_o, misalign_o and retired_o to 0.
REQ-035 SHALL discard any in-flight instruction when reset is asserted mid-operation, with no write issued on the reset edge or on the edge after it.

Structure
REQ-036 SHALL take the wb_sel enum (ALU, MEM, PC4) and the load funct3 constants (LB, LH, LW, LBU, LHU) from the shared package riscv_pkg.
REQ-037 SHALL place load extraction, sign extension and misalign detection in one combinational sub-module, riscv_load_align.

Verification
REQ-038 SHALL verify an ALU write: valid_i=1, rd=5, wb_sel=ALU, alu_result=0x1234 -> next cycle DataD_o=0x1234, AddrD_o=5, RegWEn_o=1, retired_o=1.
REQ-039 SHALL verify a signed byte load: LB, alu_result=0x103, mem_rdata=0x80FF_0000 -> DataD_o=0xFFFF_FF80; the same case with LBU -> 0x0000_0080.
REQ-040 SHALL verify an x0 target and a misaligned load:
- rd=0, reg_wen=1 -> RegWEn_o=0 and wb_valid_o=1.
- LW at 0x102 -> RegWEn_o=0, misalign_o pulses one cycle, retired_o unchanged.
REQ-041 SHALL verify stall then flush: capture JAL (wb_sel=PC4, pc=0xFFFF_FFFC, rd=1), then stall 3 cycles -> DataD_o=0 held, wb_valid_o high for only 1 cycle; then flush_i with stall_i=1 -> RegWEn_o=0 on the next cycle.
REQ-042 SHALL verify counter wrap and reset: preload retired_o to all-ones, retire one instruction -> 0; rst_i mid-stream -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: write-back source select and load funct3 encodings.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_RSV = 2'd3
  } wb_sel_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/riscv_writeback_if.sv
// Write-back stage bundle: memory-stage inputs and register-file / retire outputs.
interface riscv_writeback_if #(
  parameter int XLEN     = 32,
  parameter int RETIRE_W = 32
);
  logic                valid_i;
  logic                stall_i;
  logic                flush_i;
  logic [4:0]          rd_i;
  logic                reg_wen_i;
  logic [1:0]          wb_sel_i;
  logic [2:0]          funct3_i;
  logic [XLEN-1:0]     alu_result_i;
  logic [XLEN-1:0]     pc_i;
  logic [XLEN-1:0]     mem_rdata_i;
  logic [XLEN-1:0]     DataD_o;
  logic [4:0]          AddrD_o;
  logic                RegWEn_o;
  logic                wb_valid_o;
  logic                misalign_o;
  logic [RETIRE_W-1:0] retired_o;

  modport master (
    output valid_i, stall_i, flush_i, rd_i, reg_wen_i, wb_sel_i, funct3_i,
           alu_result_i, pc_i, mem_rdata_i,
    input  DataD_o, AddrD_o, RegWEn_o, wb_valid_o, misalign_o, retired_o
  );

  modport slave (
    input  valid_i, stall_i, flush_i, rd_i, reg_wen_i, wb_sel_i, funct3_i,
           alu_result_i, pc_i, mem_rdata_i,
    output DataD_o, AddrD_o, RegWEn_o, wb_valid_o, misalign_o, retired_o
  );
endinterface

// File: rtl/riscv_load_align.sv
// Load data extraction from an aligned word, sign/zero extension and misalign detection.
module riscv_load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic            is_load_i,
  output logic [XLEN-1:0] data_o,
  output logic            misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        bad;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Unsupported funct3 values fall through as misaligned with zero data.
  always_comb begin
    data_o = '0;
    bad    = 1'b1;
    case (funct3_i)
      LB: begin
        data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
        bad    = 1'b0;
      end
      LBU: begin
        data_o = {{(XLEN-8){1'b0}}, byte_sel};
        bad    = 1'b0;
      end
      LH: begin
        data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
        bad    = offset_i[0];
      end
      LHU: begin
        data_o = {{(XLEN-16){1'b0}}, half_sel};
        bad    = offset_i[0];
      end
      LW: begin
        data_o = rdata_i;
        bad    = |offset_i;
      end
      default: ;
    endcase
  end

  assign misalign_o = is_load_i & bad;

endmodule

// File: rtl/riscv_writeback.sv
// Write-back stage: one stage register feeding register-file write port and retire counter.
module riscv_writeback
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RETIRE_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  riscv_writeback_if.slave wb
);

  logic                valid_q;
  logic                new_q;
  logic                reg_wen_q;
  logic [4:0]          rd_q;
  wb_sel_e             wb_sel_q;
  logic [2:0]          funct3_q;
  logic [XLEN-1:0]     alu_q;
  logic [XLEN-1:0]     pc_q;
  logic [XLEN-1:0]     rdata_q;
  logic [RETIRE_W-1:0] retired_q;
  logic [RETIRE_W-1:0] retired_d;

  logic [XLEN-1:0]     load_data;
  logic [XLEN-1:0]     result;
  logic                misalign;
  logic                wb_valid;

  riscv_load_align #(.XLEN(XLEN)) u_align (
    .funct3_i   (funct3_q),
    .offset_i   (alu_q[1:0]),
    .rdata_i    (rdata_q),
    .is_load_i  (wb_sel_q == WB_MEM),
    .data_o     (load_data),
    .misalign_o (misalign)
  );

  always_comb begin
    case (wb_sel_q)
      WB_ALU:  result = alu_q;
      WB_MEM:  result = load_data;
      WB_PC4:  result = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
      default: result = '0;
    endcase
  end

  // new_q marks the first cycle an instruction is presented; stall repeats do not retire again.
  assign wb_valid  = valid_q & new_q & ~misalign;
  assign retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, wb_valid};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      new_q     <= 1'b0;
      reg_wen_q <= 1'b0;
      rd_q      <= '0;
      wb_sel_q  <= WB_ALU;
      funct3_q  <= '0;
      alu_q     <= '0;
      pc_q      <= '0;
      rdata_q   <= '0;
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
      if (wb.flush_i) begin
        valid_q <= 1'b0;
        new_q   <= 1'b0;
      end else if (wb.stall_i) begin
        new_q <= 1'b0;
      end else begin
        valid_q <= wb.valid_i;
        new_q   <= wb.valid_i;
        if (wb.valid_i) begin
          reg_wen_q <= wb.reg_wen_i;
          rd_q      <= wb.rd_i;
          wb_sel_q  <= wb_sel_e'(wb.wb_sel_i);
          funct3_q  <= wb.funct3_i;
          alu_q     <= wb.alu_result_i;
          pc_q      <= wb.pc_i;
          rdata_q   <= wb.mem_rdata_i;
        end
      end
    end
  end

  // Write enable is also blocked during reset so nothing lands on the reset edge.
  assign wb.DataD_o    = valid_q ? result : '0;
  assign wb.AddrD_o    = valid_q ? rd_q : 5'd0;
  assign wb.RegWEn_o   = valid_q & reg_wen_q & (rd_q != 5'd0) & ~misalign & ~rst_i;
  assign wb.wb_valid_o = wb_valid;
  assign wb.misalign_o = valid_q & new_q & misalign;
  assign wb.retired_o  = retired_d;

endmodule

// File: tb/tb_riscv_writeback.sv
// Randomized bench for riscv_writeback: per-cycle expected outputs queued by stimulus, popped by a monitor.
module tb_riscv_writeback;

  localparam int XLEN = 32;
  localparam int RW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_writeback_if #(.XLEN(XLEN), .RETIRE_W(RW)) bus ();

  riscv_writeback #(.XLEN(XLEN), .RETIRE_W(RW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        data_care;
    logic [4:0]  addr;
    logic        wen;
    logic        wbv;
    logic        mis;
    logic [7:0]  ret;
  } snap_t;

  snap_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model state: the instruction sitting in write-back and whether it has been presented yet.
  logic        m_valid = 1'b0;
  logic        m_pending = 1'b0;
  logic [4:0]  m_rd = '0;
  logic        m_wen = 1'b0;
  logic [1:0]  m_sel = '0;
  logic [2:0]  m_f3 = '0;
  logic [31:0] m_alu = '0, m_pc = '0, m_rdata = '0;
  int          m_cnt = 0;

  function automatic logic model_mis(logic [1:0] sel, logic [2:0] f3, logic [31:0] a);
    if (sel != 2'd1) return 1'b0;
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return a[0];
      3'd2:       return a[1:0] != 2'd0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
    logic [1:0]  off;
    logic [31:0] b, h;
    off = a[1:0];
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd4: return b;
      3'd1: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_result();
    case (m_sel)
      2'd0:    return m_alu;
      2'd1:    return model_load(m_f3, m_alu, m_rdata);
      2'd2:    return m_pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  task automatic cyc(input logic r, input logic v, input logic st, input logic fl,
                     input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                     input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc,
                     input logic [31:0] rdata);
    snap_t s;
    logic  mis;
    @(posedge clk);
    #1;
    rst = r;
    bus.valid_i = v; bus.stall_i = st; bus.flush_i = fl;
    bus.rd_i = rd; bus.reg_wen_i = wen; bus.wb_sel_i = sel; bus.funct3_i = f3;
    bus.alu_result_i = alu; bus.pc_i = pc; bus.mem_rdata_i = rdata;

    mis         = m_valid && model_mis(m_sel, m_f3, m_alu);
    s.wbv       = m_valid && m_pending && !mis;
    s.mis       = m_valid && m_pending && mis;
    s.wen       = !r && m_valid && m_wen && (m_rd != 5'd0) && !mis;
    s.addr      = m_valid ? m_rd : 5'd0;
    s.data      = m_valid ? model_result() : 32'd0;
    s.data_care = !mis;
    s.ret       = 8'((m_cnt + (s.wbv ? 1 : 0)) % 256);
    exp_q.push_back(s);

    if (r) begin
      m_valid = 1'b0; m_pending = 1'b0; m_cnt = 0;
    end else begin
      m_cnt = (m_cnt + (s.wbv ? 1 : 0)) % 256;
      if (fl) begin
        m_valid = 1'b0; m_pending = 1'b0;
      end else if (st) begin
        m_pending = 1'b0;
      end else begin
        m_valid = v; m_pending = v;
        if (v) begin
          m_rd = rd; m_wen = wen; m_sel = sel; m_f3 = f3;
          m_alu = alu; m_pc = pc; m_rdata = rdata;
        end
      end
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Monitor: the DUT presents a result every cycle; compare it against the oldest expectation.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (e.data_care && bus.DataD_o !== e.data) begin
          n_err++; $display("FAIL DataD_o t=%0t got %h want %h", $time, bus.DataD_o, e.data);
        end
        if (bus.AddrD_o !== e.addr) begin
          n_err++; $display("FAIL AddrD_o t=%0t got %0d want %0d", $time, bus.AddrD_o, e.addr);
        end
        if (bus.RegWEn_o !== e.wen) begin
          n_err++; $display("FAIL RegWEn_o t=%0t got %b want %b", $time, bus.RegWEn_o, e.wen);
        end
        if (bus.wb_valid_o !== e.wbv) begin
          n_err++; $display("FAIL wb_valid_o t=%0t got %b want %b", $time, bus.wb_valid_o, e.wbv);
        end
        if (bus.misalign_o !== e.mis) begin
          n_err++; $display("FAIL misalign_o t=%0t got %b want %b", $time, bus.misalign_o, e.mis);
        end
        if (bus.retired_o !== e.ret) begin
          n_err++; $display("FAIL retired_o t=%0t got %0d want %0d", $time, bus.retired_o, e.ret);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_i = 0; bus.stall_i = 0; bus.flush_i = 0; bus.rd_i = 0; bus.reg_wen_i = 0;
    bus.wb_sel_i = 0; bus.funct3_i = 0; bus.alu_result_i = 0; bus.pc_i = 0; bus.mem_rdata_i = 0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // ALU write, signed/unsigned byte loads, x0 target, misaligned word load
    cyc(0, 1, 0, 0, 5'd5, 1, 2'd0, 3'd0, 32'h1234, 32'h100, 32'h0);
    cyc(0, 1, 0, 0, 5'd6, 1, 2'd1, 3'd0, 32'h103, 32'h104, 32'h80FF_0000);
    cyc(0, 1, 0, 0, 5'd6, 1, 2'd1, 3'd4, 32'h103, 32'h108, 32'h80FF_0000);
    cyc(0, 1, 0, 0, 5'd0, 1, 2'd0, 3'd0, 32'hDEAD, 32'h10C, 32'h0);
    cyc(0, 1, 0, 0, 5'd7, 1, 2'd1, 3'd2, 32'h102, 32'h110, 32'hCAFE_BABE);
    idle();
    // JAL at the top of the address space, held by a 3-cycle stall, then flushed while stalled
    cyc(0, 1, 0, 0, 5'd1, 1, 2'd2, 3'd0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 1, 0, 5'd9, 1, 2'd0, 3'd0, 32'h5555, 32'h0, 32'h0);
    cyc(0, 1, 1, 1, 5'd9, 1, 2'd0, 3'd0, 32'h5555, 32'h0, 32'h0);
    idle();
    idle();

    for (int i = 0; i < 700; i++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
          ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 5),
          5'($urandom), 1'($urandom), 2'($urandom), 3'($urandom),
          $urandom, $urandom, $urandom);
    end

    // Counter wrap: from reset, 255 retirements reach all-ones, the 256th wraps to 0
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++)
      cyc(0, 1, 0, 0, 5'(i % 31 + 1), 1, 2'd0, 3'd0, $urandom, 32'h0, 32'h0);
    idle();
    // Reset in the middle of a stream
    cyc(0, 1, 0, 0, 5'd3, 1, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0);
    cyc(1, 1, 0, 0, 5'd4, 1, 2'd0, 3'd0, 32'h88, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 5'd4, 1, 2'd0, 3'd0, 32'h99, 32'h0, 32'h0);
    idle();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
